// File: rtl/neopixel_buffered_ctrl.sv
// WS2812 strip driver: 24-bit pixel buffer with a host write port, serialised
// one frame at a time (or continuously in loop mode) with a latch gap after each frame.
module neopixel_buffered_ctrl #(
  parameter int PIXELS_MAX  = 8,
  parameter int PIXELS_BITS = 3,
  parameter int T_BIT       = 12,
  parameter int T0_HIGH     = 3,
  parameter int T1_HIGH     = 8,
  parameter int RESET_DELAY = 500
) (
  input  logic                   CLK_10MHZ,
  input  logic                   RESET,
  input  logic                   WR_EN,
  input  logic [PIXELS_BITS-1:0] WR_ADDR,
  input  logic [23:0]            WR_DATA,
  input  logic [PIXELS_BITS:0]   PIXEL_COUNT,
  input  logic                   START,
  input  logic                   LOOP,
  output logic                   NEO_DATA,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [1:0]             VERBOSE_STATE
);

  localparam int TW = (T_BIT > 1) ? $clog2(T_BIT) : 1;
  localparam logic [PIXELS_BITS:0] PMAX      = (PIXELS_BITS+1)'(PIXELS_MAX);
  localparam logic [TW-1:0]        TICK_LAST = TW'(T_BIT - 1);
  localparam logic [TW-1:0]        T0_TH     = TW'(T0_HIGH);
  localparam logic [TW-1:0]        T1_TH     = TW'(T1_HIGH);
  localparam logic [15:0]          GAP_LAST  = 16'(RESET_DELAY);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRANSMIT = 2'd1,
    GAP      = 2'd2
  } state_t;

  state_t state, state_next;

  logic [23:0]            buffer [PIXELS_MAX];
  logic [23:0]            shift_reg;
  logic [TW-1:0]          tick;
  logic [4:0]             bit_idx;
  logic [PIXELS_BITS-1:0] pix;
  logic [PIXELS_BITS-1:0] pix_inc;
  logic [PIXELS_BITS:0]   n_pix;
  logic [PIXELS_BITS:0]   n_req;
  logic [15:0]            gap_cnt;
  logic                   neo_q, neo_next;
  logic                   done_q, done_next;
  logic                   launch, bit_end, pix_end, frame_end, gap_end;

  assign n_req     = (PIXEL_COUNT > PMAX) ? PMAX : PIXEL_COUNT;
  assign pix_inc   = pix + 1'b1;
  assign bit_end   = (tick == TICK_LAST);
  assign pix_end   = bit_end && (bit_idx == 5'd23);
  assign frame_end = pix_end && ({1'b0, pix} == n_pix - 1'b1);
  // The gap state lasts RESET_DELAY+1 cycles so DONE lines up with the registered wire.
  assign gap_end   = (gap_cnt == GAP_LAST);
  assign launch    = ((state == IDLE) && (START || LOOP)) ||
                     ((state == GAP) && gap_end && LOOP);

  always_ff @(posedge CLK_10MHZ) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (launch) state_next = (n_req == '0) ? GAP : TRANSMIT;
      TRANSMIT: if (frame_end) state_next = GAP;
      GAP: begin
        if (gap_end) begin
          if (launch) state_next = (n_req == '0) ? GAP : TRANSMIT;
          else        state_next = IDLE;
        end
      end
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    neo_next  = 1'b0;
    done_next = 1'b0;
    case (state)
      TRANSMIT: neo_next  = (tick < (shift_reg[23] ? T1_TH : T0_TH));
      GAP:      done_next = gap_end;
      default:  ;
    endcase
  end

  assign NEO_DATA      = neo_q;
  assign DONE          = done_q;
  assign BUSY          = (state != IDLE);
  assign VERBOSE_STATE = state;

  always_ff @(posedge CLK_10MHZ) begin
    if (RESET) begin
      tick      <= '0;
      bit_idx   <= '0;
      pix       <= '0;
      n_pix     <= '0;
      gap_cnt   <= '0;
      shift_reg <= '0;
      neo_q     <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < PIXELS_MAX; i++) buffer[i] <= '0;
    end else begin
      neo_q  <= neo_next;
      done_q <= done_next;
      if (WR_EN && ({1'b0, WR_ADDR} < PMAX)) buffer[WR_ADDR] <= WR_DATA;
      // Reloads read the buffer before this cycle's write lands, so they see the old word.
      if (launch) begin
        n_pix     <= n_req;
        tick      <= '0;
        bit_idx   <= '0;
        pix       <= '0;
        gap_cnt   <= '0;
        shift_reg <= buffer[0];
      end else if (state == TRANSMIT) begin
        if (frame_end) begin
          tick    <= '0;
          bit_idx <= '0;
          pix     <= '0;
          gap_cnt <= '0;
        end else if (pix_end) begin
          tick      <= '0;
          bit_idx   <= '0;
          pix       <= pix_inc;
          shift_reg <= buffer[pix_inc];
        end else if (bit_end) begin
          tick      <= '0;
          bit_idx   <= bit_idx + 1'b1;
          shift_reg <= {shift_reg[22:0], 1'b0};
        end else begin
          tick <= tick + 1'b1;
        end
      end else if (state == GAP) begin
        gap_cnt <= gap_end ? '0 : gap_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_neopixel_buffered_ctrl.sv
// Bench for neopixel_buffered_ctrl: default instance plus a fast-timing instance, each
// compared cycle by cycle against a waveform built from the frame timing rules.
module tb_neopixel_buffered_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [23:0] wr_data;
  logic [3:0]  pixel_count;
  logic        start1, start2, loop_r;
  logic        neo1, busy1, done1, neo2, busy2, done2;
  logic [1:0]  vs1, vs2;

  int n_cmp = 0;
  int n_bad = 0;

  // selected instance and its timing
  bit sel = 1'b0;
  int tbit = 12, t0 = 3, t1 = 8, rd = 500;

  logic [23:0] mdl_buf [8];
  logic [23:0] fw [8];
  // expected {state[1:0], neo, busy, done} after each rising edge
  logic [4:0]  exp_q[$];

  always #5 clk = ~clk;

  neopixel_buffered_ctrl dut1 (
    .CLK_10MHZ(clk), .RESET(rst), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .PIXEL_COUNT(pixel_count), .START(start1), .LOOP(loop_r && !sel),
    .NEO_DATA(neo1), .BUSY(busy1), .DONE(done1), .VERBOSE_STATE(vs1)
  );

  neopixel_buffered_ctrl #(.T_BIT(8), .T0_HIGH(2), .T1_HIGH(5), .RESET_DELAY(10)) dut2 (
    .CLK_10MHZ(clk), .RESET(rst), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .PIXEL_COUNT(pixel_count), .START(start2), .LOOP(loop_r && sel),
    .NEO_DATA(neo2), .BUSY(busy2), .DONE(done2), .VERBOSE_STATE(vs2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] observed();
    return sel ? {vs2, neo2, busy2, done2} : {vs1, neo1, busy1, done1};
  endfunction

  task automatic use_dut(input bit s);
    sel = s;
    if (s) begin tbit = 8;  t0 = 2; t1 = 5; rd = 10;  end
    else   begin tbit = 12; t0 = 3; t1 = 8; rd = 500; end
  endtask

  task automatic write_px(input int addr, input logic [23:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'(addr); wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    mdl_buf[addr] = data;
  endtask

  task automatic snap_words(input int n);
    for (int p = 0; p < 8; p++) fw[p] = (p < n) ? mdl_buf[p] : 24'h0;
  endtask

  // One frame: data bits for n pixels from fw[], then the latch gap.
  task automatic add_frame(input int n, input bit done_first);
    int total;
    total = n * 24 * tbit;
    for (int m = 0; m <= total + rd; m++) begin
      logic [1:0]  st;
      logic        neo;
      logic [23:0] w;
      int k, p, b, t;
      st  = (m < total) ? 2'd1 : 2'd2;
      neo = 1'b0;
      if (m >= 1 && m <= total) begin
        k = m - 1;
        p = k / (24 * tbit);
        b = (k / tbit) % 24;
        t = k % tbit;
        w = fw[p];
        neo = (t < (w[23-b] ? t1 : t0));
      end
      exp_q.push_back({st, neo, 1'b1, (m == 0) ? done_first : 1'b0});
    end
  endtask

  task automatic add_tail();
    exp_q.push_back({2'd0, 1'b0, 1'b0, 1'b1});
    for (int i = 0; i < 3; i++) exp_q.push_back(5'd0);
  endtask

  task automatic kick(input int cnt, input bit lp);
    @(negedge clk);
    pixel_count = 4'(cnt);
    loop_r = lp;
    if (sel) start2 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // mode 1: drop LOOP at index at; mode 2: mid-frame writes + ignored START; mode 3: RESET at index at
  task automatic play(input string name, input int mode, input int at);
    int idx;
    idx = 0;
    while (exp_q.size() > 0) begin
      logic [4:0] e;
      e = exp_q.pop_front();
      check($sformatf("%s_cyc%0d", name, idx), 32'(observed()), 32'(e));
      if (mode == 1 && idx == at) loop_r = 1'b0;
      if (mode == 2) begin
        wr_en = 1'b0;
        if (idx == at) begin
          wr_en = 1'b1; wr_addr = 3'd0; wr_data = 24'hFFFFFF;
        end
        if (idx == at + 1) begin
          wr_en = 1'b1; wr_addr = 3'd1; wr_data = 24'h000001;
        end
        start1 = (idx == at + 10);
      end
      if (mode == 3 && idx == at) begin
        rst = 1'b1;
        exp_q.delete();
      end
      idx++;
      @(negedge clk);
    end
  endtask

  task automatic one_shot(input string name, input int cnt);
    int n;
    n = (cnt > 8) ? 8 : cnt;
    snap_words(n);
    add_frame(n, 1'b0);
    add_tail();
    kick(cnt, 1'b0);
    play(name, 0, 0);
  endtask

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    pixel_count = '0; start1 = 1'b0; start2 = 1'b0; loop_r = 1'b0;
    for (int i = 0; i < 8; i++) mdl_buf[i] = 24'h0;
    repeat (3) @(negedge clk);
    check("rst_dut1", 32'({vs1, neo1, busy1, done1}), 32'd0);
    check("rst_dut2", 32'({vs2, neo2, busy2, done2}), 32'd0);
    rst = 1'b0;
    use_dut(1'b0);

    // buffer cleared by reset: a frame of zero words
    one_shot("zero_buf", 2);

    write_px(0, 24'hFF00D5);
    write_px(1, 24'h008800);
    write_px(2, 24'h000090);
    one_shot("plan3", 3);

    for (int i = 0; i < 8; i++) write_px(i, 24'($urandom));
    one_shot("clamp12", 12);
    one_shot("empty", 0);

    // loop mode, two back-to-back frames, LOOP dropped during the second
    snap_words(2);
    add_frame(2, 1'b0);
    add_frame(2, 1'b1);
    add_tail();
    kick(2, 1'b1);
    play("loop", 1, (2 * 24 * 12 + 500 + 1) + 100);

    // writes during pixel 0: pixel 0 keeps old word, pixel 1 takes the new one
    snap_words(3);
    fw[1] = 24'h000001;
    add_frame(3, 1'b0);
    add_tail();
    kick(3, 1'b0);
    play("midwr", 2, 50);
    wr_en = 1'b0;
    mdl_buf[0] = 24'hFFFFFF;
    mdl_buf[1] = 24'h000001;

    // reset at pixel 1 bit 10
    snap_words(3);
    add_frame(3, 1'b0);
    kick(3, 1'b0);
    play("rstmid", 3, (24 + 10) * 12 + 4);
    check("rstmid_after", 32'({vs1, neo1, busy1, done1}), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mdl_buf[i] = 24'h0;
    one_shot("after_rst", 3);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) write_px(i, 24'($urandom));
      one_shot($sformatf("rnd1_%0d", r), $urandom_range(0, 4));
    end

    // fast-timing instance
    use_dut(1'b1);
    write_px(0, 24'hA5C3F0);
    write_px(1, 24'h0F0F01);
    one_shot("fast2", 2);
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) write_px(i, 24'($urandom));
      one_shot($sformatf("rnd2_%0d", r), $urandom_range(0, 12));
    end
    snap_words(1);
    add_frame(1, 1'b0);
    add_frame(1, 1'b1);
    add_frame(1, 1'b1);
    add_tail();
    kick(1, 1'b1);
    n = (1 * 24 * 8 + 10 + 1);
    play("fastloop", 1, 2 * n + 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
